// File: rtl/pcm_access_scheduler.sv
// pcm_access_scheduler: FIFO-queued PCM request issue with fixed asymmetric read/write service latency
module pcm_access_scheduler #(
  parameter int DEPTH = 4,
  parameter int READ_LAT = 4,
  parameter int WRITE_LAT = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        schedule,
  input  logic        req_write,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        pcm_cmd_valid,
  output logic        pcm_cmd_write,
  output logic [19:0] pcm_addr,
  output logic [15:0] pcm_wdata,
  input  logic [15:0] pcm_rdata,
  output logic        resolved,
  output logic [15:0] rd_data,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2((READ_LAT > WRITE_LAT ? READ_LAT : WRITE_LAT) + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic [36:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CW-1:0] cnt;
  logic push, pop, last;
  assign req_ready = count != (AW+1)'(DEPTH);
  assign push = schedule && req_ready;
  assign pop = state == IDLE && count != '0;
  assign last = cnt == CW'(1);
  assign pcm_cmd_valid = state == ISSUE;
  assign resolved = state == DONE;
  assign busy = count != '0 || state != IDLE;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = pop ? ISSUE : IDLE;
      ISSUE: state_nxt = WAIT;
      WAIT: state_nxt = last ? DONE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {req_write, req_addr, req_wdata};
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cnt <= '0;
      pcm_cmd_write <= 1'b0;
      pcm_addr <= '0;
      pcm_wdata <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        {pcm_cmd_write, pcm_addr, pcm_wdata} <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (state == ISSUE) cnt <= pcm_cmd_write ? CW'(WRITE_LAT) : CW'(READ_LAT);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (state == WAIT && last && !pcm_cmd_write) rd_data <= pcm_rdata;
    end
  end
endmodule

// File: tb/tb_pcm_access_scheduler.sv
// tb_pcm_access_scheduler: randomized self-checking bench against a timing and ordering reference model
module tb_pcm_access_scheduler;
  localparam int DEPTH = 4;
  localparam int READ_LAT = 4;
  localparam int WRITE_LAT = 12;
  typedef struct {int a; int s; int r; bit w; logic [19:0] addr; logic [15:0] wdata; logic [15:0] rd;} req_t;
  typedef struct {int c; bit w; logic [19:0] addr; logic [15:0] wdata;} iss_t;
  typedef struct {int c; logic [15:0] rd;} res_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic schedule = 1'b0;
  logic req_write = 1'b0;
  logic [19:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] pcm_rdata = '0;
  logic req_ready, pcm_cmd_valid, pcm_cmd_write, resolved, busy;
  logic [19:0] pcm_addr;
  logic [15:0] pcm_wdata, rd_data;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_r = -100;
  int rd_due = -1;
  logic [15:0] last_rd = '0;
  logic [15:0] rd_val = '0;
  logic [15:0] arr_mem [int];
  logic [15:0] ref_mem [int];
  req_t exp_q[$];
  iss_t iss_q[$];
  res_t res_q[$];

  pcm_access_scheduler #(.DEPTH(DEPTH), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)) dut (
    .clk(clk), .reset(reset), .schedule(schedule), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .pcm_cmd_valid(pcm_cmd_valid),
    .pcm_cmd_write(pcm_cmd_write), .pcm_addr(pcm_addr), .pcm_wdata(pcm_wdata),
    .pcm_rdata(pcm_rdata), .resolved(resolved), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pcm_cmd_valid) begin
      iss_q.push_back('{cyc, pcm_cmd_write, pcm_addr, pcm_wdata});
      if (pcm_cmd_write) arr_mem[int'(pcm_addr)] = pcm_wdata;
      else begin
        rd_val = arr_mem.exists(int'(pcm_addr)) ? arr_mem[int'(pcm_addr)] : ~pcm_addr[15:0];
        rd_due = cyc + READ_LAT;
      end
    end
    if (resolved) res_q.push_back('{cyc, rd_data});
    pcm_rdata = (cyc == rd_due) ? rd_val : 16'($urandom);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic model_reset();
    exp_q.delete();
    iss_q.delete();
    res_q.delete();
    last_r = -100;
    last_rd = '0;
    ref_mem = arr_mem;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    iss_q.delete();
    res_q.delete();
  endtask

  task automatic send(input bit w, input logic [19:0] addr, input logic [15:0] wdata);
    int occ = 0;
    req_t e;
    foreach (exp_q[i]) if (exp_q[i].a <= cyc && exp_q[i].s > cyc) occ++;
    schedule = 1'b1;
    req_write = w;
    req_addr = addr;
    req_wdata = wdata;
    if (occ < DEPTH) begin
      e.a = cyc + 1;
      e.s = (e.a + 1 > last_r + 2) ? e.a + 1 : last_r + 2;
      e.r = e.s + 1 + (w ? WRITE_LAT : READ_LAT);
      if (w) ref_mem[int'(addr)] = wdata;
      else last_rd = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : ~addr[15:0];
      e.w = w;
      e.addr = addr;
      e.wdata = wdata;
      e.rd = last_rd;
      last_r = e.r;
      exp_q.push_back(e);
    end
    @(negedge clk);
    schedule = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    schedule = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, pcm_cmd_valid, pcm_cmd_write, resolved, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/write/resolved/busy=%b, required 10000", {req_ready, pcm_cmd_valid, pcm_cmd_write, resolved, busy});
    end
    checks++;
    if ({pcm_addr, pcm_wdata, rd_data} !== 52'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rd_data=%h, required all zero", pcm_addr, pcm_wdata, rd_data);
    end
    reset = 1'b0;
    schedule = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_sched_ignored: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single_read();
    int acc;
    clear_logs();
    arr_mem[32'h12345] = 16'hBEEF;
    ref_mem[32'h12345] = 16'hBEEF;
    acc = cyc + 1;
    send(1'b0, 20'h12345, 16'h0000);
    wait_idle();
    checks++;
    if (iss_q.size() != exp_q.size() || res_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL read_count: issued %0d resolved %0d, required %0d", iss_q.size(), res_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (iss_q[i].c != exp_q[i].s || iss_q[i].w != exp_q[i].w || iss_q[i].addr !== exp_q[i].addr || iss_q[i].wdata !== exp_q[i].wdata || res_q[i].c != exp_q[i].r || res_q[i].rd !== exp_q[i].rd) begin
        errors++;
        $display("FAIL read_req%0d: issue@%0d w%0b a=%h d=%h res@%0d rd=%h, required issue@%0d w%0b a=%h d=%h res@%0d rd=%h", i, iss_q[i].c, iss_q[i].w, iss_q[i].addr, iss_q[i].wdata, res_q[i].c, res_q[i].rd, exp_q[i].s, exp_q[i].w, exp_q[i].addr, exp_q[i].wdata, exp_q[i].r, exp_q[i].rd);
      end
    end
    checks++;
    if (res_q.size() != 1 || res_q[0].c != acc + 6 || rd_data !== 16'hBEEF || pcm_addr !== 20'h12345 || pcm_cmd_write !== 1'b0) begin
      errors++;
      $display("FAIL read_latency: resolved@%0d rd_data=%h addr=%h write=%b, required resolved@%0d rd_data=beef addr=12345 write=0", res_q[0].c, rd_data, pcm_addr, pcm_cmd_write, acc + 6);
    end
  endtask

  task automatic test_single_write();
    int acc;
    clear_logs();
    acc = cyc + 1;
    send(1'b1, 20'h00010, 16'hA5A5);
    wait_idle();
    checks++;
    if (iss_q.size() != exp_q.size() || res_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL write_count: issued %0d resolved %0d, required %0d", iss_q.size(), res_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (iss_q[i].c != exp_q[i].s || iss_q[i].w != exp_q[i].w || iss_q[i].addr !== exp_q[i].addr || iss_q[i].wdata !== exp_q[i].wdata || res_q[i].c != exp_q[i].r || res_q[i].rd !== exp_q[i].rd) begin
        errors++;
        $display("FAIL write_req%0d: issue@%0d w%0b a=%h d=%h res@%0d rd=%h, required issue@%0d w%0b a=%h d=%h res@%0d rd=%h", i, iss_q[i].c, iss_q[i].w, iss_q[i].addr, iss_q[i].wdata, res_q[i].c, res_q[i].rd, exp_q[i].s, exp_q[i].w, exp_q[i].addr, exp_q[i].wdata, exp_q[i].r, exp_q[i].rd);
      end
    end
    checks++;
    if (res_q.size() != 1 || res_q[0].c != acc + 14 || rd_data !== 16'hBEEF || pcm_wdata !== 16'hA5A5 || pcm_cmd_write !== 1'b1) begin
      errors++;
      $display("FAIL write_latency: resolved@%0d rd_data=%h wdata=%h write=%b, required resolved@%0d rd_data=beef wdata=a5a5 write=1", res_q[0].c, rd_data, pcm_wdata, pcm_cmd_write, acc + 14);
    end
  endtask

  task automatic test_raw_order();
    clear_logs();
    send(1'b1, 20'h00020, 16'h1111);
    send(1'b0, 20'h00020, 16'h0000);
    wait_idle();
    checks++;
    if (iss_q.size() != exp_q.size() || res_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL raw_count: issued %0d resolved %0d, required %0d", iss_q.size(), res_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (iss_q[i].c != exp_q[i].s || iss_q[i].w != exp_q[i].w || iss_q[i].addr !== exp_q[i].addr || iss_q[i].wdata !== exp_q[i].wdata || res_q[i].c != exp_q[i].r || res_q[i].rd !== exp_q[i].rd) begin
        errors++;
        $display("FAIL raw_req%0d: issue@%0d w%0b a=%h d=%h res@%0d rd=%h, required issue@%0d w%0b a=%h d=%h res@%0d rd=%h", i, iss_q[i].c, iss_q[i].w, iss_q[i].addr, iss_q[i].wdata, res_q[i].c, res_q[i].rd, exp_q[i].s, exp_q[i].w, exp_q[i].addr, exp_q[i].wdata, exp_q[i].r, exp_q[i].rd);
      end
    end
    checks++;
    if (iss_q.size() != 2 || res_q.size() < 1 || !iss_q[0].w || iss_q[1].w || iss_q[1].c <= res_q[0].c || rd_data !== 16'h1111) begin
      errors++;
      $display("FAIL raw_order: read issue@%0d write resolved@%0d rd_data=%h, required read after write resolve and rd_data=1111", iss_q[1].c, res_q[0].c, rd_data);
    end
  endtask

  task automatic test_overflow();
    clear_logs();
    send(1'b1, 20'h00400, 16'($urandom));
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++;
          $display("FAIL overflow_ready: req_ready=%b with 4 queued, required 0", req_ready);
        end
      end
      send(k[0], 20'h00410 + 20'(k), 16'($urandom));
    end
    wait_idle();
    checks++;
    if (iss_q.size() != exp_q.size() || res_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL overflow_count: issued %0d resolved %0d, required %0d", iss_q.size(), res_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (iss_q[i].c != exp_q[i].s || iss_q[i].w != exp_q[i].w || iss_q[i].addr !== exp_q[i].addr || iss_q[i].wdata !== exp_q[i].wdata || res_q[i].c != exp_q[i].r || res_q[i].rd !== exp_q[i].rd) begin
        errors++;
        $display("FAIL overflow_req%0d: issue@%0d w%0b a=%h d=%h res@%0d rd=%h, required issue@%0d w%0b a=%h d=%h res@%0d rd=%h", i, iss_q[i].c, iss_q[i].w, iss_q[i].addr, iss_q[i].wdata, res_q[i].c, res_q[i].rd, exp_q[i].s, exp_q[i].w, exp_q[i].addr, exp_q[i].wdata, exp_q[i].r, exp_q[i].rd);
      end
    end
  endtask

  task automatic test_full_push_pop();
    int n = 0;
    clear_logs();
    send(1'b1, 20'h00500, 16'($urandom));
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) send(~k[0], 20'h00510 + 20'(k), 16'($urandom));
    while (!resolved && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || n >= 100) begin
      errors++;
      $display("FAIL fpp_full: req_ready=%b wait=%0d, required full queue (0) at pop", req_ready, n);
    end
    send(1'b0, 20'h00599, 16'h0000);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL fpp_after: req_ready=%b after push+pop at full, required 1 (count 3)", req_ready);
    end
    wait_idle();
    checks++;
    if (iss_q.size() != exp_q.size() || res_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL fpp_count: issued %0d resolved %0d, required %0d", iss_q.size(), res_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (iss_q[i].c != exp_q[i].s || iss_q[i].w != exp_q[i].w || iss_q[i].addr !== exp_q[i].addr || iss_q[i].wdata !== exp_q[i].wdata || res_q[i].c != exp_q[i].r || res_q[i].rd !== exp_q[i].rd) begin
        errors++;
        $display("FAIL fpp_req%0d: issue@%0d w%0b a=%h d=%h res@%0d rd=%h, required issue@%0d w%0b a=%h d=%h res@%0d rd=%h", i, iss_q[i].c, iss_q[i].w, iss_q[i].addr, iss_q[i].wdata, res_q[i].c, res_q[i].rd, exp_q[i].s, exp_q[i].w, exp_q[i].addr, exp_q[i].wdata, exp_q[i].r, exp_q[i].rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    clear_logs();
    send(1'b0, 20'h00100, 16'($urandom));
    send(1'b0, 20'h00200, 16'($urandom));
    send(1'b0, 20'h00300, 16'($urandom));
    @(negedge clk);
    reset = 1'b1;
    schedule = 1'b1;
    req_write = 1'b0;
    req_addr = 20'h00777;
    @(negedge clk);
    reset = 1'b0;
    schedule = 1'b0;
    checks++;
    if ({busy, pcm_cmd_valid, resolved, req_ready, pcm_cmd_write} !== 5'b00010 || {pcm_addr, pcm_wdata, rd_data} !== 52'h0) begin
      errors++;
      $display("FAIL reset_mid: busy/valid/resolved/ready/write=%b addr=%h wdata=%h rd=%h, required 00010 and zeros", {busy, pcm_cmd_valid, resolved, req_ready, pcm_cmd_write}, pcm_addr, pcm_wdata, rd_data);
    end
    model_reset();
    repeat (20) @(negedge clk);
    checks++;
    if (iss_q.size() != 0 || res_q.size() != 0) begin
      errors++;
      $display("FAIL reset_discard: issued %0d resolved %0d after reset, required 0 0", iss_q.size(), res_q.size());
    end
    acc = cyc + 1;
    send(1'b0, 20'h00300, 16'h0000);
    wait_idle();
    checks++;
    if (iss_q.size() != exp_q.size() || res_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rstmid_count: issued %0d resolved %0d, required %0d", iss_q.size(), res_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (iss_q[i].c != exp_q[i].s || iss_q[i].w != exp_q[i].w || iss_q[i].addr !== exp_q[i].addr || iss_q[i].wdata !== exp_q[i].wdata || res_q[i].c != exp_q[i].r || res_q[i].rd !== exp_q[i].rd || res_q[i].c != acc + 6) begin
        errors++;
        $display("FAIL rstmid_req%0d: issue@%0d a=%h res@%0d rd=%h, required issue@%0d a=%h res@%0d rd=%h", i, iss_q[i].c, iss_q[i].addr, res_q[i].c, res_q[i].rd, exp_q[i].s, exp_q[i].addr, acc + 6, exp_q[i].rd);
      end
    end
  endtask

  task automatic test_random();
    clear_logs();
    for (int k = 0; k < 40; k++) begin
      send(1'($urandom_range(0, 1)), 20'h00800 + 20'($urandom_range(0, 7)), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    checks++;
    if (iss_q.size() != exp_q.size() || res_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: issued %0d resolved %0d, required %0d", iss_q.size(), res_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (iss_q[i].c != exp_q[i].s || iss_q[i].w != exp_q[i].w || iss_q[i].addr !== exp_q[i].addr || iss_q[i].wdata !== exp_q[i].wdata || res_q[i].c != exp_q[i].r || res_q[i].rd !== exp_q[i].rd) begin
        errors++;
        $display("FAIL random_req%0d: issue@%0d w%0b a=%h d=%h res@%0d rd=%h, required issue@%0d w%0b a=%h d=%h res@%0d rd=%h", i, iss_q[i].c, iss_q[i].w, iss_q[i].addr, iss_q[i].wdata, res_q[i].c, res_q[i].rd, exp_q[i].s, exp_q[i].w, exp_q[i].addr, exp_q[i].wdata, exp_q[i].r, exp_q[i].rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_raw_order();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
